// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
//
// Purpose:
//   Sequences one data-memory access per MEM-stage load/store over a
//   request/ready handshake. Freezes the front of the pipeline while the
//   access is outstanding, aborts accesses that exceed TIMEOUT cycles, and
//   drops misaligned accesses with an error pulse.
//
// Parameters:
//   TIMEOUT   maximum ACCESS-state cycles before abort (1..255)
//   ERR_DATA  read data returned on a timed-out load
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   MEM_MemRead / MEM_MemWrite MEM-stage load / store
//   MEM_ALU_out                byte address of the access
//   MEM_register_read_data2    store data
//   mem_ready / mem_rdata      memory completion and read data
//   mem_req / mem_we           request to memory, write enable
//   mem_addr / mem_wdata       latched word address and store data
//   stall                      freeze IF/ID/EX and EX/MEM this cycle
//   MEM_read_data              load result forwarded to MEM/WB
//   err_misaligned             one-cycle pulse, misaligned access dropped
//   err_timeout                one-cycle pulse, access aborted by timeout
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
   parameter int unsigned TIMEOUT  = 16,
   parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MEM_MemRead,
   input  logic        MEM_MemWrite,
   input  logic [31:0] MEM_ALU_out,
   input  logic [31:0] MEM_register_read_data2,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        stall,
   output logic [31:0] MEM_read_data,
   output logic        err_misaligned,
   output logic        err_timeout
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_mis_q, err_mis_d;
   logic        err_to_q, err_to_d;

   logic access_req;
   logic aligned;
   logic start;

   assign access_req = MEM_MemRead | MEM_MemWrite;
   assign aligned    = (MEM_ALU_out[1:0] == 2'b00);
   assign start      = access_req & aligned & (state_q == IDLE);

   // DONE deliberately leaves stall low so exactly one instruction leaves MEM.
   assign stall = ~reset & (start | (state_q == ACCESS));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         we_q      <= 1'b0;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         rdata_q   <= 32'd0;
         err_mis_q <= 1'b0;
         err_to_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         err_mis_q <= err_mis_d;
         err_to_q  <= err_to_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      err_mis_d = 1'b0;
      err_to_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               // A load+store combination is treated as a store.
               addr_d  = {MEM_ALU_out[31:2], 2'b00};
               wdata_d = MEM_register_read_data2;
               we_d    = MEM_MemWrite;
               cnt_d   = 8'd0;
               state_d = ACCESS;
            end else if (access_req) begin
               // Requested but not started while idle: must be misaligned.
               err_mis_d = 1'b1;
            end
         end

         ACCESS: begin
            // Completion wins over a timeout in the same cycle.
            if (mem_ready) begin
               if (!we_q) begin
                  rdata_d = mem_rdata;
               end
               state_d = DONE;
            end else if (cnt_q == CNT_LIMIT) begin
               err_to_d = 1'b1;
               if (!we_q) begin
                  rdata_d = ERR_DATA;
               end
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The request is exactly the ACCESS state, so its fields are stable
   // until the cycle after mem_ready is sampled.
   assign mem_req        = (state_q == ACCESS);
   assign mem_we         = we_q;
   assign mem_addr       = addr_q;
   assign mem_wdata      = wdata_q;
   assign MEM_read_data  = rdata_q;
   assign err_misaligned = err_mis_q;
   assign err_timeout    = err_to_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

   localparam int K_RST = 0;
   localparam int K_ACC = 1;
   localparam int K_MIS = 2;

   logic        clk;
   logic        reset;
   logic        MEM_MemRead;
   logic        MEM_MemWrite;
   logic [31:0] MEM_ALU_out;
   logic [31:0] MEM_register_read_data2;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        stall;
   logic [31:0] MEM_read_data;
   logic        err_misaligned;
   logic        err_timeout;

   dmem_access_ctrl #(
      .TIMEOUT (16),
      .ERR_DATA(32'hDEAD_BEEF)
   ) dut (
      .clk                    (clk),
      .reset                  (reset),
      .MEM_MemRead            (MEM_MemRead),
      .MEM_MemWrite           (MEM_MemWrite),
      .MEM_ALU_out            (MEM_ALU_out),
      .MEM_register_read_data2(MEM_register_read_data2),
      .mem_ready              (mem_ready),
      .mem_rdata              (mem_rdata),
      .mem_req                (mem_req),
      .mem_we                 (mem_we),
      .mem_addr               (mem_addr),
      .mem_wdata              (mem_wdata),
      .stall                  (stall),
      .MEM_read_data          (MEM_read_data),
      .err_misaligned         (err_misaligned),
      .err_timeout            (err_timeout)
   );

   typedef struct {
      int          kind;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          req_cyc;
      int          stall_cyc;
      logic        err_to;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   // memory model controls
   int          ready_after = 0;   // ready on this request cycle, 0 = never
   logic        stray_ready = 1'b0;
   logic [31:0] rd_cfg      = 32'd0;
   int          req_cnt     = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic take(input int kind, input string what, output exp_t e, output bit ok);
      checks++;
      ok = 1'b0;
      if (sb_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_%s actual=event required=none", what);
      end else begin
         e = sb_q.pop_front();
         if (e.kind != kind) begin
            failures++;
            $display("FAIL order_%s actual kind=%0d required kind=%0d", what, kind, e.kind);
         end else begin
            ok = 1'b1;
         end
      end
   endtask

   function automatic void push_rst();
      exp_t e;
      e = '{K_RST, 1'b0, 32'd0, 32'd0, 32'd0, 0, 0, 1'b0};
      sb_q.push_back(e);
   endfunction

   function automatic void push_acc(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                    input logic [31:0] rd, input int rq, input int st, input logic to);
      exp_t e;
      e = '{K_ACC, we, addr, wd, rd, rq, st, to};
      sb_q.push_back(e);
   endfunction

   function automatic void push_mis(input logic [31:0] rd);
      exp_t e;
      e = '{K_MIS, 1'b0, 32'd0, 32'd0, rd, 0, 0, 1'b0};
      sb_q.push_back(e);
   endfunction

   // Memory responder: mem_ready on the programmed request cycle, optional
   // stray ready while no request is outstanding.
   always @(posedge clk) begin
      #1;
      if (mem_req) begin
         req_cnt++;
         mem_ready = (ready_after != 0) && (req_cnt == ready_after);
      end else begin
         req_cnt   = 0;
         mem_ready = stray_ready;
      end
      mem_rdata = rd_cfg;
   end

   // Monitor
   logic        prev_rst   = 1'b0;
   logic        prev_req   = 1'b0;
   logic        prev_stall = 1'b0;
   logic        unstable   = 1'b0;
   logic        mon_done;
   int          req_run    = 0;
   int          stall_run  = 0;
   logic        we0;
   logic [31:0] a0, w0;
   exp_t        me;
   bit          mok;

   always @(negedge clk) begin
      if (reset) begin
         if (prev_rst) begin
            take(K_RST, "reset", me, mok);
            if (mok) begin
               chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
               chk("rst_stall", {31'd0, stall}, 32'd0);
               chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
               chk("rst_mem_addr", mem_addr, 32'd0);
               chk("rst_mem_wdata", mem_wdata, 32'd0);
               chk("rst_read_data", MEM_read_data, me.rdata);
               chk("rst_err_mis", {31'd0, err_misaligned}, 32'd0);
               chk("rst_err_to", {31'd0, err_timeout}, 32'd0);
            end
         end
         prev_req   = 1'b0;
         prev_stall = 1'b0;
         req_run    = 0;
         stall_run  = 0;
         unstable   = 1'b0;
      end else begin
         mon_done = prev_req && !mem_req;
         if (mem_req) begin
            if (!prev_req) begin
               we0      = mem_we;
               a0       = mem_addr;
               w0       = mem_wdata;
               req_run  = 1;
               unstable = 1'b0;
            end else begin
               req_run++;
               if ({mem_we, mem_addr, mem_wdata} !== {we0, a0, w0}) unstable = 1'b1;
            end
         end
         if (mon_done) begin
            take(K_ACC, "access", me, mok);
            if (mok) begin
               chk("acc_we", {31'd0, we0}, {31'd0, me.we});
               chk("acc_addr", a0, me.addr);
               chk("acc_wdata", w0, me.wdata);
               chk("acc_stable", {31'd0, unstable}, 32'd0);
               chk("acc_req_cycles", req_run, me.req_cyc);
               chk("acc_stall_cycles", stall_run, me.stall_cyc);
               chk("acc_stall_done", {31'd0, stall}, 32'd0);
               chk("acc_read_data", MEM_read_data, me.rdata);
               chk("acc_err_timeout", {31'd0, err_timeout}, {31'd0, me.err_to});
            end
         end
         if (err_misaligned) begin
            take(K_MIS, "misaligned", me, mok);
            if (mok) begin
               chk("mis_stall", {31'd0, prev_stall}, 32'd0);
               chk("mis_no_req", {30'd0, prev_req, mem_req}, 32'd0);
               chk("mis_read_data", MEM_read_data, me.rdata);
            end
         end
         if (err_timeout && !mon_done) begin
            checks++;
            failures++;
            $display("FAIL stray_err_timeout actual=1 required=0");
         end
         stall_run  = stall ? stall_run + 1 : 0;
         prev_stall = stall;
         prev_req   = mem_req;
      end
      prev_rst = reset;
   end

   // Present one instruction in MEM and hold it until the pipeline advances.
   task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input int rdy, input logic [31:0] rdv);
      bit released;
      int c;
      MEM_MemRead             = rd;
      MEM_MemWrite            = wr;
      MEM_ALU_out             = addr;
      MEM_register_read_data2 = wd;
      ready_after             = rdy;
      rd_cfg                  = rdv;
      released = 1'b0;
      c = 0;
      while (!released && c < 100) begin
         @(negedge clk);
         if (!stall) released = 1'b1;
         c++;
      end
      if (!released) begin
         checks++;
         failures++;
         $display("FAIL issue_bound actual=stall_held required=release_within_100");
      end
      @(posedge clk);
      #1;
      MEM_MemRead  = 1'b0;
      MEM_MemWrite = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset                   = 1'b1;
      MEM_MemRead             = 1'b0;
      MEM_MemWrite            = 1'b0;
      MEM_ALU_out             = 32'd0;
      MEM_register_read_data2 = 32'd0;
      mem_ready               = 1'b0;
      mem_rdata               = 32'd0;
      push_rst();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      idle(1);

      // load, ready on the 3rd request cycle
      push_acc(1'b0, 32'h100, 32'h1111_1111, 32'hCAFE_F00D, 3, 4, 1'b0);
      issue(1'b1, 1'b0, 32'h100, 32'h1111_1111, 3, 32'hCAFE_F00D);
      idle(1);

      // store, ready on the first request cycle; read data untouched
      push_acc(1'b1, 32'h204, 32'h1234_5678, 32'hCAFE_F00D, 1, 2, 1'b0);
      issue(1'b0, 1'b1, 32'h204, 32'h1234_5678, 1, 32'h5555_5555);
      idle(1);

      // load and store together behave as a store
      push_acc(1'b1, 32'h208, 32'hA5A5_A5A5, 32'hCAFE_F00D, 2, 3, 1'b0);
      issue(1'b1, 1'b1, 32'h208, 32'hA5A5_A5A5, 2, 32'h6666_6666);
      idle(1);

      // misaligned load and store, with stray mem_ready while idle
      stray_ready = 1'b1;
      push_mis(32'hCAFE_F00D);
      issue(1'b1, 1'b0, 32'h102, 32'h0, 1, 32'h7777_7777);
      idle(2);
      push_mis(32'hCAFE_F00D);
      issue(1'b0, 1'b1, 32'h201, 32'hFFFF_0000, 1, 32'h7777_7777);
      idle(2);
      stray_ready = 1'b0;
      idle(1);

      // load timeout: 16 request cycles, ERR_DATA returned
      push_acc(1'b0, 32'h300, 32'h0, 32'hDEAD_BEEF, 16, 17, 1'b1);
      issue(1'b1, 1'b0, 32'h300, 32'h0, 0, 32'h1357_9BDF);
      idle(1);

      // ready exactly at the timeout limit counts as completion
      push_acc(1'b0, 32'h304, 32'h0, 32'h0BAD_F00D, 16, 17, 1'b0);
      issue(1'b1, 1'b0, 32'h304, 32'h0, 16, 32'h0BAD_F00D);

      // back-to-back loads, no idle gap
      push_acc(1'b0, 32'h10, 32'h0, 32'h1111_0010, 1, 2, 1'b0);
      issue(1'b1, 1'b0, 32'h10, 32'h0, 1, 32'h1111_0010);
      push_acc(1'b0, 32'h14, 32'h0, 32'h2222_0014, 1, 2, 1'b0);
      issue(1'b1, 1'b0, 32'h14, 32'h0, 1, 32'h2222_0014);
      idle(1);

      // store timeout: read data untouched
      push_acc(1'b1, 32'h400, 32'hBEEF_0400, 32'h2222_0014, 16, 17, 1'b1);
      issue(1'b0, 1'b1, 32'h400, 32'hBEEF_0400, 0, 32'h0);
      idle(1);

      // reset in the 2nd ACCESS cycle of a load
      push_rst();
      MEM_MemRead  = 1'b1;
      MEM_ALU_out  = 32'h500;
      ready_after  = 3;
      rd_cfg       = 32'h5A5A_5A5A;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset       = 1'b1;
      MEM_MemRead = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      idle(2);

      // recovery after reset
      push_acc(1'b0, 32'h20, 32'h0, 32'h0000_0077, 1, 2, 1'b0);
      issue(1'b1, 1'b0, 32'h20, 32'h0, 1, 32'h0000_0077);
      idle(5);

      chk("scoreboard_empty", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
